// File: rtl/cskips_serial_sub.sv
// Block-serial carry-skip subtractor: D = A - B, one 4-bit block per clock,
// least significant block first. Each block adds A_blk + ~B_blk + carry and
// bypasses the ripple carry when all four propagate bits are set.
//
// Handshake (both sides): a transfer happens on a rising edge where the
// sender's valid and the receiver's ready are both high. o_ready is high only
// in IDLE. o_valid is high only in DONE, and the result outputs hold still
// until the edge on which i_ready is seen high.
module cskips_serial_sub #(
  parameter  int WIDTH = 24,
  localparam int NBLK  = WIDTH / 4,
  localparam int CW    = $clog2(NBLK + 1),
  localparam int IW    = $clog2(NBLK)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic [CW-1:0]    o_skip_cnt,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;

  logic [3:0] a_blk, nb_blk, p_blk;
  logic [4:0] sum5;
  logic       skip_blk, carry_next, last_blk;

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign dbg_state = state_q;

  // Current block slice, ripple sum and skip-path carry selection.
  always_comb begin
    a_blk      = a_q[{idx_q, 2'b00} +: 4];
    nb_blk     = ~b_q[{idx_q, 2'b00} +: 4];
    p_blk      = a_blk ^ nb_blk;
    sum5       = {1'b0, a_blk} + {1'b0, nb_blk} + {4'b0000, carry_q};
    skip_blk   = &p_blk;
    // With every propagate bit set the block passes its carry-in straight
    // through; the ripple carry-out would be identical.
    carry_next = skip_blk ? carry_q : sum5[4];
    last_blk   = (idx_q == IW'(NBLK - 1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, walk blocks in RUN, hand off in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)  state_d = RUN;
      RUN:     if (last_blk) state_d = DONE;
      DONE:    if (i_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-block result write-back and final flag update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      diff       <= '0;
      bout       <= 1'b0;
      ovf        <= 1'b0;
      o_skip_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q        <= i_sub_term1;
            b_q        <= i_sub_term2;
            carry_q    <= 1'b1;  // the +1 of two's-complement negation
            idx_q      <= '0;
            o_skip_cnt <= '0;
          end
        end
        RUN: begin
          diff[{idx_q, 2'b00} +: 4] <= sum5[3:0];
          carry_q <= carry_next;
          idx_q   <= idx_q + IW'(1);
          if (skip_blk) o_skip_cnt <= o_skip_cnt + CW'(1);
          if (last_blk) begin
            bout <= ~carry_next;
            // sum5[3] is the result MSB while the top block is processed.
            ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum5[3] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
